// File: rtl/m_unit_issue_ctrl.sv
// Issue/sequencing controller between EX and the RV32M unit: registers one op,
// pulses it into the M unit, stalls EX until it returns, and owns the shared writeback port.
module m_unit_issue_ctrl #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_m_valid,
    input  logic [31:0]      ex_instr,
    input  logic [XLEN-1:0]  ex_rs1_val,
    input  logic [XLEN-1:0]  ex_rs2_val,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             flush,
    output logic             mu_valid,
    output logic [31:0]      mu_instruction,
    output logic [XLEN-1:0]  mu_rs1,
    output logic [XLEN-1:0]  mu_rs2,
    output logic [REG_W-1:0] mu_rd,
    input  logic             mu_ready,
    input  logic             mu_wr,
    input  logic [XLEN-1:0]  mu_result,
    input  logic             alu_wb_valid,
    input  logic [REG_W-1:0] alu_wb_rd,
    input  logic [XLEN-1:0]  alu_wb_data,
    output logic             wb_en,
    output logic [REG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data,
    output logic             alu_wb_hold,
    output logic             stall_ex,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DRAIN
    } state_e;

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
    logic [CNT_W-1:0] tmo_cnt_inc;
    logic             tmo_hit;
    logic             in_watch;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    // Watchdog fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
    assign in_watch    = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign tmo_cnt_inc = tmo_cnt_q + CNT_W'(1);
    assign tmo_hit     = in_watch && (tmo_cnt_inc == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        result_d    = result_q;
        tmo_cnt_d   = in_watch ? tmo_cnt_inc : '0;
        tmo_err_d   = tmo_err_q;
        mu_valid    = 1'b0;
        stall_ex    = 1'b0;
        wb_en       = alu_wb_valid;
        wb_rd       = alu_wb_rd;
        wb_data     = alu_wb_data;
        alu_wb_hold = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall_ex = ex_m_valid;
                if (ex_m_valid && !flush) begin
                    instr_d = ex_instr;
                    rs1_d   = ex_rs1_val;
                    rs2_d   = ex_rs2_val;
                    rd_d    = ex_rd;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mu_valid = 1'b1;
                stall_ex = 1'b1;
                state_d  = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall_ex = 1'b1;
                if (flush) begin
                    // A result arriving with the flush is already consumed, so no drain is needed.
                    state_d = mu_ready ? S_IDLE : S_DRAIN;
                end else if (mu_ready) begin
                    if (mu_wr) begin
                        result_d = mu_result;
                        state_d  = S_WB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WB: begin
                if (rd_q != '0) begin
                    wb_en       = 1'b1;
                    wb_rd       = rd_q;
                    wb_data     = result_q;
                    alu_wb_hold = alu_wb_valid;
                end
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                stall_ex = ex_m_valid;
                if (mu_ready) begin
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mu_instruction = instr_q;
    assign mu_rs1         = rs1_q;
    assign mu_rs2         = rs2_q;
    assign mu_rd          = rd_q;
    assign timeout_err    = tmo_err_q;

endmodule

// File: tb/tb_m_unit_issue_ctrl.sv
// Randomized bench for m_unit_issue_ctrl; expectations are derived per transaction
// (operands, latency, rd, ALU contention) rather than per controller state.
module tb_m_unit_issue_ctrl;

    localparam int unsigned TMO = 16;
    localparam logic [31:0] MUL_X5  = 32'h022082B3;
    localparam logic [31:0] DIVU_X6 = 32'h0220D333;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_m_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        mu_valid;
    logic [31:0] mu_instruction, mu_rs1, mu_rs2;
    logic [4:0]  mu_rd;
    logic        mu_ready, mu_wr;
    logic [31:0] mu_result;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        alu_wb_hold, stall_ex, timeout_err;

    int nvec = 0;
    int nerr = 0;

    m_unit_issue_ctrl #(
        .XLEN(32),
        .REG_W(5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .ex_m_valid(ex_m_valid), .ex_instr(ex_instr), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .flush(flush),
        .mu_valid(mu_valid), .mu_instruction(mu_instruction), .mu_rs1(mu_rs1),
        .mu_rs2(mu_rs2), .mu_rd(mu_rd),
        .mu_ready(mu_ready), .mu_wr(mu_wr), .mu_result(mu_result),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .alu_wb_hold(alu_wb_hold), .stall_ex(stall_ex), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1);
    end

    task automatic idle_inputs();
        ex_m_valid = 1'b0; ex_instr = '0; ex_rs1_val = '0; ex_rs2_val = '0; ex_rd = '0;
        flush = 1'b0; mu_ready = 1'b0; mu_wr = 1'b0; mu_result = '0;
        alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
    endtask

    // Drives one complete M op starting in an idle cycle; lat = cycles from mu_valid to mu_ready.
    task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input bit wr,
                          input logic [31:0] res, input bit alu_v, input logic [4:0] alu_rd,
                          input logic [31:0] alu_d);
        bit          hold;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic [70:0] exp_wb;
        hold = (rd != 5'd0) && alu_v;
        flush = 1'b0; mu_ready = 1'b0; mu_wr = 1'b0; alu_wb_valid = 1'b0;
        ex_m_valid = 1'b1; ex_instr = ins; ex_rs1_val = a; ex_rs2_val = b; ex_rd = rd;
        #1;
        nvec++;
        if ({mu_valid, stall_ex} !== 2'b01) begin
            nerr++; $display("FAIL accept: mu_valid,stall_ex=%b required 01", {mu_valid, stall_ex});
        end
        @(negedge clk);
        ex_instr = $urandom; ex_rs1_val = $urandom; ex_rs2_val = $urandom; ex_rd = 5'($urandom);
        for (int c = 0; c <= lat; c++) begin
            av = 1'($urandom); ard = 5'($urandom); ad = $urandom;
            alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = ad;
            mu_ready  = (c == lat);
            mu_wr     = (c == lat) ? wr : 1'($urandom);
            mu_result = (c == lat) ? res : $urandom;
            #1;
            nvec++;
            if ({mu_valid, stall_ex, mu_instruction, mu_rs1, mu_rs2, mu_rd} !==
                {(c == 0), 1'b1, ins, a, b, rd}) begin
                nerr++;
                $display("FAIL issue_wait c=%0d: got v=%b st=%b ins=%h rs1=%h rs2=%h rd=%0d required v=%b st=1 ins=%h rs1=%h rs2=%h rd=%0d",
                         c, mu_valid, stall_ex, mu_instruction, mu_rs1, mu_rs2, mu_rd,
                         (c == 0), ins, a, b, rd);
            end
            nvec++;
            if ({wb_en, wb_rd, wb_data, alu_wb_hold} !== {av, ard, ad, 1'b0}) begin
                nerr++;
                $display("FAIL alu_passthru c=%0d: got en=%b rd=%0d d=%h hold=%b required en=%b rd=%0d d=%h hold=0",
                         c, wb_en, wb_rd, wb_data, alu_wb_hold, av, ard, ad);
            end
            @(negedge clk);
        end
        mu_ready = 1'b0; mu_wr = 1'b0; mu_result = $urandom;
        if (wr) begin
            alu_wb_valid = alu_v; alu_wb_rd = alu_rd; alu_wb_data = alu_d;
            #1;
            if (rd != 5'd0) exp_wb = {1'b1, rd, res, hold, 1'b0, 1'b0};
            else            exp_wb = {alu_v, alu_rd, alu_d, 1'b0, 1'b0, 1'b0};
            nvec++;
            if ({wb_en, wb_rd, wb_data, alu_wb_hold, stall_ex, mu_valid} !== exp_wb) begin
                nerr++;
                $display("FAIL wb_cycle: got en=%b rd=%0d d=%h hold=%b st=%b v=%b required %h",
                         wb_en, wb_rd, wb_data, alu_wb_hold, stall_ex, mu_valid, exp_wb);
            end
            @(negedge clk);
            ex_m_valid = 1'b0; alu_wb_valid = 1'b0;
            if (hold) begin
                alu_wb_valid = 1'b1;
                #1;
                nvec++;
                if ({wb_en, wb_rd, wb_data, alu_wb_hold, stall_ex} !== {1'b1, alu_rd, alu_d, 1'b0, 1'b0}) begin
                    nerr++;
                    $display("FAIL alu_replay: got en=%b rd=%0d d=%h hold=%b st=%b required en=1 rd=%0d d=%h hold=0 st=0",
                             wb_en, wb_rd, wb_data, alu_wb_hold, stall_ex, alu_rd, alu_d);
                end
                @(negedge clk);
                alu_wb_valid = 1'b0;
            end
        end else begin
            ex_m_valid = 1'b0; alu_wb_valid = 1'b0;
            #1;
            nvec++;
            if ({wb_en, stall_ex, mu_valid} !== 3'b000) begin
                nerr++; $display("FAIL no_write: en,st,v=%b required 000", {wb_en, stall_ex, mu_valid});
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #3;
        nvec++;
        if ({mu_valid, mu_instruction, mu_rs1, mu_rs2, mu_rd, wb_en, alu_wb_hold, stall_ex, timeout_err} !== '0) begin
            nerr++; $display("FAIL reset_outputs: got nonzero outputs v=%b ins=%h rd=%0d err=%b required all 0",
                             mu_valid, mu_instruction, mu_rd, timeout_err);
        end
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        run_op(MUL_X5, 32'd7, 32'd6, 5'd5, 3, 1'b1, 32'd42, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_divu_alu_hold();
        run_op(DIVU_X6, 32'd100, 32'd0, 5'd6, 2, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd7, 32'h0000_1234);
    endtask

    task automatic test_rd_zero();
        run_op(32'h02208033, 32'd9, 32'd9, 5'd0, 1, 1'b1, 32'd81, 1'b1, 5'd12, 32'hCAFE_F00D);
        run_op(MUL_X5, 32'd5, 32'd5, 5'd4, 2, 1'b0, 32'd25, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_flush();
        // flush while EX presents an op: nothing accepted
        idle_inputs();
        ex_m_valid = 1'b1; ex_instr = MUL_X5; ex_rd = 5'd5; flush = 1'b1;
        #1;
        nvec++;
        if (stall_ex !== 1'b1) begin nerr++; $display("FAIL flush_idle_stall: got %b required 1", stall_ex); end
        @(negedge clk);
        ex_m_valid = 1'b0; flush = 1'b0;
        #1;
        nvec++;
        if (mu_valid !== 1'b0) begin nerr++; $display("FAIL flush_idle_noissue: got %b required 0", mu_valid); end
        @(negedge clk);
        // flush two cycles into WAIT
        ex_m_valid = 1'b1; ex_rs1_val = 32'd11; ex_rs2_val = 32'd13; ex_rd = 5'd3;
        @(negedge clk); @(negedge clk); @(negedge clk);
        flush = 1'b1;
        #1;
        nvec++;
        if ({mu_valid, stall_ex} !== 2'b01) begin nerr++; $display("FAIL flush_wait: v,st=%b required 01", {mu_valid, stall_ex}); end
        @(negedge clk);
        flush = 1'b0; ex_instr = DIVU_X6; ex_rd = 5'd6;
        #1;
        nvec++;
        if ({mu_valid, stall_ex, wb_en} !== 3'b010) begin nerr++; $display("FAIL drain_hold: v,st,en=%b required 010", {mu_valid, stall_ex, wb_en}); end
        @(negedge clk);
        ex_m_valid = 1'b0;
        #1;
        nvec++;
        if ({mu_valid, stall_ex, wb_en} !== 3'b000) begin nerr++; $display("FAIL drain_release: v,st,en=%b required 000", {mu_valid, stall_ex, wb_en}); end
        @(negedge clk);
        mu_ready = 1'b1; mu_wr = 1'b1; mu_result = 32'd143;
        #1;
        nvec++;
        if ({wb_en, stall_ex} !== 2'b00) begin nerr++; $display("FAIL drain_ready: en,st=%b required 00", {wb_en, stall_ex}); end
        @(negedge clk);
        mu_ready = 1'b0; mu_wr = 1'b0;
        #1;
        nvec++;
        if ({wb_en, stall_ex, mu_valid, timeout_err} !== 4'b0000) begin
            nerr++; $display("FAIL drain_exit: en,st,v,err=%b required 0000", {wb_en, stall_ex, mu_valid, timeout_err});
        end
        @(negedge clk);
        // flush coincident with mu_ready: straight back to idle
        ex_m_valid = 1'b1; ex_rd = 5'd8;
        @(negedge clk); @(negedge clk);
        flush = 1'b1; mu_ready = 1'b1; mu_wr = 1'b1; mu_result = 32'hDEAD_BEEF;
        @(negedge clk);
        flush = 1'b0; mu_ready = 1'b0; mu_wr = 1'b0; ex_m_valid = 1'b0;
        #1;
        nvec++;
        if ({wb_en, stall_ex} !== 2'b00) begin nerr++; $display("FAIL flush_ready: en,st=%b required 00", {wb_en, stall_ex}); end
        run_op(MUL_X5, 32'd2, 32'd21, 5'd5, 1, 1'b1, 32'd42, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_timeout();
        idle_inputs();
        ex_m_valid = 1'b1; ex_instr = MUL_X5; ex_rs1_val = 32'd1; ex_rs2_val = 32'd1; ex_rd = 5'd5;
        @(negedge clk);
        ex_m_valid = 1'b0;
        @(negedge clk);
        for (int j = 0; j < int'(TMO); j++) begin
            #1;
            nvec++;
            if ({timeout_err, stall_ex, wb_en} !== {(j == int'(TMO) - 1), (j < int'(TMO) - 1), 1'b0}) begin
                nerr++; $display("FAIL timeout j=%0d: err,st,en=%b required %b%b0", j,
                                 {timeout_err, stall_ex, wb_en}, (j == int'(TMO) - 1), (j < int'(TMO) - 1));
            end
            @(negedge clk);
        end
        run_op(MUL_X5, 32'd4, 32'd4, 5'd2, 2, 1'b1, 32'd16, 1'b0, 5'd0, 32'd0);
        nvec++;
        if (timeout_err !== 1'b1) begin nerr++; $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
    endtask

    task automatic test_reset_mid_op();
        idle_inputs();
        ex_m_valid = 1'b1; ex_instr = MUL_X5; ex_rs1_val = 32'd8; ex_rs2_val = 32'd8; ex_rd = 5'd9;
        @(negedge clk); @(negedge clk); @(negedge clk);
        resetn = 1'b0; ex_m_valid = 1'b0; mu_ready = 1'b1; mu_wr = 1'b1; mu_result = 32'd64;
        #1;
        nvec++;
        if ({mu_valid, mu_instruction, mu_rs1, mu_rs2, mu_rd, wb_en, alu_wb_hold, stall_ex, timeout_err} !== '0) begin
            nerr++; $display("FAIL reset_mid: got v=%b ins=%h rs1=%h rd=%0d en=%b st=%b err=%b required all 0",
                             mu_valid, mu_instruction, mu_rs1, mu_rd, wb_en, stall_ex, timeout_err);
        end
        @(negedge clk);
        resetn = 1'b1; mu_ready = 1'b0; mu_wr = 1'b0;
        #1;
        nvec++;
        if ({wb_en, stall_ex, mu_valid} !== 3'b000) begin nerr++; $display("FAIL reset_release: en,st,v=%b required 000", {wb_en, stall_ex, mu_valid}); end
        run_op(32'h022080B3, 32'd3, 32'd3, 5'd1, 2, 1'b1, 32'd9, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [4:0]  rd;
        for (int n = 0; n < 40; n++) begin
            a  = $urandom; b = $urandom;
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_op($urandom, a, b, rd, int'($urandom_range(1, 6)), ($urandom_range(0, 4) != 0),
                   a * b, 1'($urandom), 5'($urandom), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_divu_alu_hold();
        test_rd_zero();
        test_flush();
        test_timeout();
        test_reset_mid_op();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/m_unit_issue_ctrl.md
Name: m_unit_issue_ctrl

Overview:
Sequencing controller between the EX stage and the RV32M multiply/divide unit. Accepts one M-extension instruction at a time from EX and registers its operands. Issues a single-cycle valid pulse to the M unit, freezes the pipeline until the result returns, and arbitrates the shared register-file write port against the ALU writeback. Also handles flush of an in-flight op, suppression of x0 writes, and a hang watchdog.

Parameters:
XLEN, 32, datapath width
REG_W, 5, register index width
TIMEOUT_CYCLES, 64, max cycles in WAIT/DRAIN before abort

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
ex_m_valid  in  1  EX holds an M-extension instruction
ex_instr  in  32  instruction word
ex_rs1_val  in  XLEN  rs1 operand value
ex_rs2_val  in  XLEN  rs2 operand value
ex_rd  in  REG_W  destination register
flush  in  1  kill the instruction owned by this block
mu_valid  out  1  issue pulse to M unit
mu_instruction  out  32  registered instruction to M unit
mu_rs1  out  XLEN  registered operand 1
mu_rs2  out  XLEN  registered operand 2
mu_rd  out  REG_W  registered destination
mu_ready  in  1  M unit result valid
mu_wr  in  1  M unit requests writeback
mu_result  in  XLEN  M unit result
alu_wb_valid  in  1  ALU writeback request, same cycle
alu_wb_rd  in  REG_W  ALU destination
alu_wb_data  in  XLEN  ALU data
wb_en  out  1  register-file write enable
wb_rd  out  REG_W  write address
wb_data  out  XLEN  write data
alu_wb_hold  out  1  ALU writeback deferred this cycle
stall_ex  out  1  freeze IF/ID/EX
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async, resetn=0): state=IDLE; mu_valid, mu_* registers, result register, timeout counter and timeout_err all 0. Reset mid-operation drops the op with no writeback.
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE:
  - If ex_m_valid && !flush: latch ex_instr, ex_rs1_val, ex_rs2_val and ex_rd into the mu_* registers; go to ISSUE.
  - stall_ex = ex_m_valid (combinational).
- ISSUE:
  - mu_valid=1 for exactly this cycle; stall_ex=1.
  - flush -> DRAIN; else -> WAIT.
- WAIT:
  - stall_ex=1; the timeout counter increments each cycle.
  - mu_ready && mu_wr -> latch mu_result, go to WB.
  - mu_ready && !mu_wr -> IDLE, no write.
  - flush -> DRAIN. If flush and mu_ready occur together, flush wins: the result is discarded and the state goes to IDLE.
- WB:
  - wb_en = (mu_rd != 0); wb_rd=mu_rd; wb_data=latched result; stall_ex=0 (EX retires the M instruction at this edge); next state IDLE.
  - ex_m_valid in WB is ignored; it still reflects the retiring instruction.
  - flush in WB is ignored; the op has committed.
- DRAIN:
  - Waits for mu_ready, then discards the result and goes to IDLE.
  - stall_ex = ex_m_valid.
  - The timeout counter keeps running.
- ALU writeback arbitration:
  - Outside WB: wb_* pass through alu_wb_*; alu_wb_hold=0.
  - In WB the M result has priority; alu_wb_hold = alu_wb_valid. The pipeline must replay the ALU write next cycle.
  - In WB with mu_rd=0, the ALU gets the port and alu_wb_hold=0.
- Watchdog:
  - The counter is cleared whenever the state is outside WAIT/DRAIN.
  - If it reaches TIMEOUT_CYCLES-1 while still in WAIT/DRAIN: set timeout_err (sticky until reset), go to IDLE, no writeback, stall released.
- Throughput: at most one op in flight. A back-to-back M instruction is accepted in the IDLE cycle after WB.
- Operand registers hold stable from ISSUE until the return to IDLE.

Test Plan:
- MUL x5 = 7*6, M unit ready 3 cycles after mu_valid -> mu_valid high 1 cycle; stall_ex high from the accept cycle through WAIT; WB cycle wb_en=1, wb_rd=5, wb_data=42, stall_ex=0.
- DIVU 100/0 with M unit returning 0xFFFFFFFF, alu_wb_valid=1 (rd=7) in the WB cycle -> wb_rd=mu_rd, wb_data=0xFFFFFFFF, alu_wb_hold=1; next cycle ALU write passes through, alu_wb_hold=0.
- flush asserted 2 cycles into WAIT, then mu_ready -> state DRAIN then IDLE; wb_en never driven by the M path; timeout_err=0.
- MUL with rd=0 and alu_wb_valid=1 in the WB cycle -> wb_en follows the ALU request, alu_wb_hold=0.
- mu_ready tied 0 after issue -> timeout_err=1 exactly TIMEOUT_CYCLES-1 cycles after entering WAIT; state IDLE; stall_ex=0; no write.
- resetn pulled low for 1 cycle during WAIT -> immediately all outputs 0, state IDLE; a later MUL 3*3 to x1 completes with wb_data=9.
